aes_final_addkey_out: RTL

Output stage directly downstream of the AES last round (SubBytes+ShiftRows). It XORs the 128-bit last-round state with round key 10 (final AddRoundKey) to form the ciphertext. Each ciphertext block is buffered in a small FIFO and streamed out as 32-bit words over a valid/ready interface. Decouples the round pipeline from a narrower, possibly stalling, consumer (bus/UART bridge).

---
 rtl/aes_pkg.sv | 34 +++
 rtl/add_round_key.sv | 20 ++
 rtl/aes_final_addkey_out.sv | 114 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared AES widths, block/word typedefs and a word-select helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int AES_BLOCK_W       = 128;
  localparam int AES_WORD_W        = 32;
  localparam int AES_WORDS_PER_BLK = AES_BLOCK_W / AES_WORD_W;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [AES_WORD_W-1:0]  aes_word_t;
  typedef logic [1:0]             aes_beat_t;

  localparam aes_beat_t AES_LAST_BEAT = 2'd3;

  // Word 0 is the most significant word, matching byte 0 at [127:120].
  function automatic aes_word_t aes_word_sel(input aes_block_t blk, input aes_beat_t beat);
    aes_word_t w;
    case (beat)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage : aes_pkg

`default_nettype wire

// File: rtl/add_round_key.sv
// ============================================================================
// Module  : add_round_key
// Brief   : AES AddRoundKey, a pure 128-bit XOR of state and round key.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_round_key
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_i,
  input  logic [AES_BLOCK_W-1:0] key_i,
  output logic [AES_BLOCK_W-1:0] state_o
);

  assign state_o = state_i ^ key_i;

endmodule : add_round_key

`default_nettype wire

// File: rtl/aes_final_addkey_out.sv
// ============================================================================
// Module  : aes_final_addkey_out
// Brief   : Final AddRoundKey, block FIFO and 128->32 bit ciphertext serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_final_addkey_out
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int BLK_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           state_in,
  input  logic [127:0]           round_key,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_word,
  output logic                   out_last,
  output logic [BLK_CNT_W-1:0]   blk_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  aes_block_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  aes_beat_t             beat_q, beat_d;
  logic [BLK_CNT_W-1:0]  blk_count_q, blk_count_d;

  aes_block_t            cipher_blk;
  logic                  push;
  logic                  pop_beat;
  logic                  pop_blk;

  add_round_key u_add_round_key (
    .state_i (state_in),
    .key_i   (round_key),
    .state_o (cipher_blk)
  );

  // Gating with the reset pin keeps in_ready low throughout reset and lets it
  // rise in the very first cycle after release.
  assign in_ready  = reset && (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_last  = out_valid && (beat_q == AES_LAST_BEAT);
  assign out_word  = out_valid ? aes_word_sel(mem_q[rptr_q], beat_q) : '0;
  assign blk_count = blk_count_q;

  assign push     = in_valid && in_ready;
  assign pop_beat = out_valid && out_ready;
  assign pop_blk  = pop_beat && (beat_q == AES_LAST_BEAT);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    beat_d      = beat_q;
    blk_count_d = blk_count_q;

    if (push) begin
      wptr_d = wptr_q + PTR_W'(1);
    end

    if (pop_beat) begin
      beat_d = beat_q + 2'd1;
    end

    if (pop_blk) begin
      rptr_d      = rptr_q + PTR_W'(1);
      blk_count_d = blk_count_q + BLK_CNT_W'(1);
    end

    // Push and final-beat pop together leave the occupancy unchanged.
    case ({push, pop_blk})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      beat_q      <= '0;
      blk_count_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      beat_q      <= beat_d;
      blk_count_q <= blk_count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= cipher_blk;
    end
  end

endmodule : aes_final_addkey_out

`default_nettype wire
